mem_arbiter: RTL

Shares one memory server port between `p_num_clients` requesters, such as fetch and load/store, so that they can sit behind a single memory. Requests are selected by round-robin arbitration. Each forwarded request has its client index appended above the client opaque field; responses are routed back by that index, with the original opaque restored. Per-client outstanding-request counters limit in-flight traffic and stop one client from filling the server's response queue.

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory server port between N clients; responses routed back by an index stored above the opaque field.
// Zero-latency combinational request/response paths; per-client in-flight limits withhold grants rather than stalling the server.
module mem_arbiter #(
    parameter int p_num_clients     = 2,
    parameter int p_opaq_bits       = 8,
    parameter int p_max_outstanding = 4,
    localparam int p_idx_bits       = $clog2(p_num_clients),
    localparam int p_sopaq_bits     = p_opaq_bits + p_idx_bits
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [p_num_clients-1:0]                 creq_val,
    output logic [p_num_clients-1:0]                 creq_rdy,
    input  logic [p_num_clients-1:0]                 creq_op,
    input  logic [p_num_clients-1:0][p_opaq_bits-1:0] creq_opaque,
    input  logic [p_num_clients-1:0][31:0]           creq_addr,
    input  logic [p_num_clients-1:0][31:0]           creq_data,
    output logic [p_num_clients-1:0]                 cresp_val,
    input  logic [p_num_clients-1:0]                 cresp_rdy,
    output logic [p_num_clients-1:0]                 cresp_op,
    output logic [p_num_clients-1:0][p_opaq_bits-1:0] cresp_opaque,
    output logic [p_num_clients-1:0][31:0]           cresp_data,
    output logic                                     sreq_val,
    input  logic                                     sreq_rdy,
    output logic                                     sreq_op,
    output logic [p_sopaq_bits-1:0]                  sreq_opaque,
    output logic [31:0]                              sreq_addr,
    output logic [31:0]                              sreq_data,
    input  logic                                     sresp_val,
    output logic                                     sresp_rdy,
    input  logic                                     sresp_op,
    input  logic [p_sopaq_bits-1:0]                  sresp_opaque,
    input  logic [31:0]                              sresp_data
);
    localparam int lp_cnt_bits = $clog2(p_max_outstanding + 1);
    localparam int lp_trace_len = 3 + 2 * p_num_clients;

    logic [p_idx_bits-1:0]                       r_ptr;
    logic [p_num_clients-1:0][lp_cnt_bits-1:0]   r_cnt;

    logic [p_num_clients-1:0] w_elig;
    logic [p_num_clients-1:0] w_inc;
    logic [p_num_clients-1:0] w_dec;
    logic [p_idx_bits-1:0]    w_grant;
    logic [p_idx_bits-1:0]    w_scan;
    logic [p_idx_bits-1:0]    w_ptr_nxt;
    logic [p_idx_bits-1:0]    w_k;
    logic                     w_any;
    logic                     w_k_ok;
    logic                     w_req_fire;
    logic                     w_resp_fire;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < p_num_clients; i++) begin
            w_elig[i] = creq_val[i] && (r_cnt[i] < lp_cnt_bits'(p_max_outstanding));
        end
    end

    // First eligible client scanning upward from the priority pointer.
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        w_scan  = '0;
        for (int i = 0; i < p_num_clients; i++) begin
            w_scan = p_idx_bits'((int'(r_ptr) + i) % p_num_clients);
            if (!w_any && w_elig[w_scan]) begin
                w_any   = 1'b1;
                w_grant = w_scan;
            end
        end
    end

    assign w_ptr_nxt   = (int'(w_grant) == p_num_clients - 1) ? '0 : w_grant + 1'b1;
    assign sreq_val    = w_any && !rst;
    assign sreq_op     = creq_op[w_grant];
    assign sreq_opaque = {w_grant, creq_opaque[w_grant]};
    assign sreq_addr   = creq_addr[w_grant];
    assign sreq_data   = creq_data[w_grant];
    assign w_req_fire  = sreq_val && sreq_rdy;

    assign w_k         = sresp_opaque[p_sopaq_bits-1 -: p_idx_bits];
    assign w_k_ok      = int'(w_k) < p_num_clients;
    assign sresp_rdy   = !rst && w_k_ok && cresp_rdy[w_k];
    assign w_resp_fire = sresp_val && sresp_rdy;

    always_comb begin
        creq_rdy     = '0;
        cresp_val    = '0;
        cresp_op     = '0;
        cresp_opaque = '0;
        cresp_data   = '0;
        w_inc        = '0;
        w_dec        = '0;
        for (int i = 0; i < p_num_clients; i++) begin
            creq_rdy[i]     = !rst && sreq_rdy && w_elig[i] && (w_grant == p_idx_bits'(i));
            cresp_val[i]    = !rst && sresp_val && (w_k == p_idx_bits'(i));
            cresp_op[i]     = sresp_op;
            cresp_opaque[i] = sresp_opaque[p_opaq_bits-1:0];
            cresp_data[i]   = sresp_data;
            w_inc[i]        = w_req_fire && (w_grant == p_idx_bits'(i));
            w_dec[i]        = w_resp_fire && (w_k == p_idx_bits'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else begin
            if (w_req_fire) begin
                r_ptr <= w_ptr_nxt;
            end
            // Same-cycle issue and retire for one client cancel out.
            for (int i = 0; i < p_num_clients; i++) begin
                case ({w_inc[i], w_dec[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + lp_cnt_bits'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - lp_cnt_bits'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    a_resp_idx: assert property (@(posedge clk) disable iff (rst) sresp_val |-> w_k_ok);
    a_resp_cnt: assert property (@(posedge clk) disable iff (rst) w_resp_fire |-> (r_cnt[w_k] != '0));

    function automatic logic [7:0] f_hex(input logic [3:0] v);
        return (v < 4'd10) ? (8'h30 + 8'(v)) : (8'h57 + 8'(v));
    endfunction

    // "<ptr> <grant|.>" then " <cnt>" per client; level 0 masks counters as '-'.
    function automatic logic [8*lp_trace_len-1:0] trace(input int level);
        logic [8*lp_trace_len-1:0] s;
        s = '0;
        s[8*lp_trace_len-1 -: 8]     = f_hex(4'(r_ptr));
        s[8*(lp_trace_len-1)-1 -: 8] = 8'h20;
        s[8*(lp_trace_len-2)-1 -: 8] = w_any ? f_hex(4'(w_grant)) : 8'h2E;
        for (int i = 0; i < p_num_clients; i++) begin
            s[8*(lp_trace_len-3-2*i)-1 -: 8] = 8'h20;
            s[8*(lp_trace_len-4-2*i)-1 -: 8] = (level > 0) ? f_hex(4'(r_cnt[i])) : 8'h2D;
        end
        return s;
    endfunction

endmodule
